// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared word type, arbiter state encoding and abort pattern.
// Rev     : 1.0  initial release
//==============================================================================
package mem_arbiter_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   // Returned on the load path when an access times out
   localparam word_t c_abort_word = 32'hBAD1BAD1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_grant_counter.sv
`default_nettype none
//==============================================================================
// Module  : arb_grant_counter
// Brief   : Saturating streak counter with increment, clear and at-limit flag.
// Rev     : 1.0  initial release
//==============================================================================
module arb_grant_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int CW = $clog2(MAX + 1);
   localparam logic [CW-1:0] c_max = CW'(MAX);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign at_limit = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : mem_arbiter
// Brief   : Shares one single-ported RAM between instruction fetch and data.
// Rev     : 1.0  initial release
//==============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [DATA_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [DATA_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dhit,
   output logic              merr,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [DATA_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ramready
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]     c_tlast = TW'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] c_abort = DATA_W'(c_abort_word);

   arb_state_t    r_state, w_next;
   logic [TW-1:0] r_tcnt;
   logic          w_dgrant, w_igrant, w_done, w_abort;
   logic          w_at_limit;

   arb_grant_counter #(
      .MAX (MAX_DSTREAK)
   ) u_streak (
      .clk      (clk),
      .nRST     (nRST),
      .inc      (w_dgrant & iREN),
      .clr      ((w_dgrant & ~iREN) | w_igrant),
      .at_limit (w_at_limit)
   );

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_dgrant = 1'b0;
      w_igrant = 1'b0;
      w_done   = 1'b0;
      w_abort  = 1'b0;
      case (r_state)
         IDLE: begin
            // Data wins unless fetch has waited through a full data streak
            if ((dREN || dWEN) && (!iREN || !w_at_limit)) begin
               w_next   = DACC;
               w_dgrant = 1'b1;
            end else if (iREN) begin
               w_next   = IACC;
               w_igrant = 1'b1;
            end
         end
         IACC, DACC: begin
            if (ramready) begin
               w_next = RESP;
               w_done = 1'b1;
            end else if (r_tcnt == c_tlast) begin
               w_next  = RESP;
               w_abort = 1'b1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         iload    <= '0;
         dload    <= '0;
         ihit     <= 1'b0;
         dhit     <= 1'b0;
         merr     <= 1'b0;
         r_tcnt   <= '0;
      end else begin
         ihit <= 1'b0;
         dhit <= 1'b0;
         merr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_dgrant) begin
                  ramaddr  <= daddr;
                  ramstore <= dstore;
                  ramWEN   <= dWEN;
                  ramREN   <= ~dWEN;
               end else if (w_igrant) begin
                  ramaddr <= iaddr;
                  ramWEN  <= 1'b0;
                  ramREN  <= 1'b1;
               end
            end
            IACC, DACC: begin
               if (w_done || w_abort) begin
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
                  ihit   <= (r_state == IACC);
                  dhit   <= (r_state == DACC);
                  merr   <= w_abort;
                  // ramWEN still carries the latched op while in DACC
                  if (r_state == IACC)  iload <= w_abort ? c_abort : ramload;
                  else if (w_abort)     dload <= c_abort;
                  else if (!ramWEN)     dload <= ramload;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            RESP:    r_tcnt <= '0;
            default: r_tcnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench: directed scenarios plus randomized traffic.
// Rev     : 1.0  initial release
//==============================================================================
module tb_mem_arbiter;

   localparam int DATA_W      = 32;
   localparam int MAX_DSTREAK = 4;
   localparam int TIMEOUT     = 255;

   logic              clk = 1'b0;
   logic              nRST;
   logic              iREN, dREN, dWEN, ramready;
   logic [DATA_W-1:0] iaddr, daddr, dstore, ramload;
   logic [DATA_W-1:0] iload, dload, ramaddr, ramstore;
   logic              ihit, dhit, merr, ramREN, ramWEN;

   always #5 clk = ~clk;

   mem_arbiter #(
      .DATA_W      (DATA_W),
      .MAX_DSTREAK (MAX_DSTREAK),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk      (clk),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .ihit     (ihit),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dhit     (dhit),
      .merr     (merr),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramready (ramready)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          ram_delay   = 1;
   int          ram_n       = 0;
   bit          ram_tie0    = 1'b0;
   bit          rand_delay  = 1'b0;
   bit          junk_en     = 1'b0;
   bit          auto_drop_d = 1'b1;
   bit          p_ihit      = 1'b0;
   bit          p_dhit      = 1'b0;
   logic [31:0] exp_dload   = 32'h0;

   // Contents of a RAM word that was never written
   function automatic logic [31:0] def_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : def_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
   endfunction

   // One clock: requesters drop after their hit, RAM answers, outputs sampled
   task automatic step();
      @(posedge clk);
      #1;
      if (p_ihit) iREN = 1'b0;
      if (p_dhit && auto_drop_d) begin
         dREN = 1'b0;
         dWEN = 1'b0;
      end
      if (ramREN || ramWEN) begin
         ram_n++;
         if (ram_n == 1 && rand_delay) ram_delay = $urandom_range(0, 3);
         if (!ram_tie0 && ram_n == ram_delay + 1) begin
            ramready = 1'b1;
            if (ramWEN) ram_mem[ramaddr] = ramstore;
            else        ramload = ram_rd(ramaddr);
         end else begin
            ramready = 1'b0;
            ramload  = $urandom;
         end
      end else begin
         ram_n    = 0;
         ramready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
         ramload  = $urandom;
      end
      cyc++;
      @(negedge clk);
      p_ihit = ihit;
      p_dhit = dhit;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
      repeat (2) step();
      n_cmp++;
      if ({ramREN, ramWEN, ihit, dhit, merr} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 00000", {ramREN, ramWEN, ihit, dhit, merr});
      end
      n_cmp++;
      if ({iload, dload} !== 64'h0) begin
         n_bad++; $display("FAIL reset_load: got %h/%h want 0/0", iload, dload);
      end
      n_cmp++;
      if ({ramaddr, ramstore} !== 64'h0) begin
         n_bad++; $display("FAIL reset_ram: got %h/%h want 0/0", ramaddr, ramstore);
      end
      nRST = 1'b1;
      repeat (2) step();
      n_cmp++;
      if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
         n_bad++; $display("FAIL idle_quiet: got %b want 0000", {ramREN, ramWEN, ihit, dhit});
      end
   endtask

   task automatic test_ifetch();
      int exp_hit;
      ram_mem[32'h40] = 32'h8C010004;
      ram_delay = 2;
      exp_hit   = 1 + ram_delay + 1;
      iaddr = 32'h40; iREN = 1'b1; cyc = 0;
      for (int c = 1; c <= exp_hit + 1; c++) begin
         step();
         if (c == 1) begin
            n_cmp++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
               n_bad++; $display("FAIL ifetch_strobe: got ren=%b wen=%b addr=%h want 1 0 40", ramREN, ramWEN, ramaddr);
            end
         end else if (c == exp_hit) begin
            n_cmp++;
            if (ihit !== 1'b1 || iload !== 32'h8C010004 || ramREN !== 1'b0 || merr !== 1'b0) begin
               n_bad++; $display("FAIL ifetch_hit: got hit=%b load=%h ren=%b merr=%b want 1 8c010004 0 0", ihit, iload, ramREN, merr);
            end
         end else begin
            n_cmp++;
            if (ihit !== 1'b0) begin
               n_bad++; $display("FAIL ifetch_nohit: cycle %0d got ihit=%b want 0", c, ihit);
            end
         end
      end
   endtask

   task automatic test_drop_mid();
      int hits = 0;
      ram_mem[32'h60] = 32'h12345678;
      ram_delay = 3;
      iaddr = 32'h60; iREN = 1'b1; cyc = 0;
      step();
      iREN = 1'b0;
      for (int c = 2; c <= 7; c++) begin
         step();
         if (ihit) hits++;
         if (c == 1 + ram_delay + 1) begin
            n_cmp++;
            if (ihit !== 1'b1 || iload !== 32'h12345678) begin
               n_bad++; $display("FAIL drop_mid_hit: got hit=%b load=%h want 1 12345678", ihit, iload);
            end
         end
      end
      n_cmp++;
      if (hits != 1) begin
         n_bad++; $display("FAIL drop_mid_count: got %0d hits want 1", hits);
      end
   endtask

   task automatic test_priority();
      int exp_dh, exp_ih, nd = 0, ni = 0;
      ram_mem[32'h100] = 32'hA5A50100;
      ram_mem[32'h44]  = 32'hC0DE0044;
      ram_delay = 1;
      exp_dh = 1 + ram_delay + 1;
      exp_ih = exp_dh + 2 + ram_delay + 1;
      daddr = 32'h100; dREN = 1'b1; iaddr = 32'h44; iREN = 1'b1; cyc = 0;
      for (int c = 1; c <= exp_ih + 1; c++) begin
         step();
         nd += int'(dhit); ni += int'(ihit);
         if (c == 1) begin
            n_cmp++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
               n_bad++; $display("FAIL prio_data_first: got ren=%b addr=%h want 1 100", ramREN, ramaddr);
            end
         end
         if (c == exp_dh) begin
            n_cmp++;
            if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'hA5A50100) begin
               n_bad++; $display("FAIL prio_dhit: got dhit=%b ihit=%b dload=%h want 1 0 a5a50100", dhit, ihit, dload);
            end
         end
         if (c == exp_ih - 2) begin
            n_cmp++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
               n_bad++; $display("FAIL prio_fetch_strobe: got ren=%b addr=%h want 1 44", ramREN, ramaddr);
            end
         end
         if (c == exp_ih) begin
            n_cmp++;
            if (ihit !== 1'b1 || iload !== 32'hC0DE0044) begin
               n_bad++; $display("FAIL prio_ihit: got ihit=%b iload=%h want 1 c0de0044", ihit, iload);
            end
         end
      end
      exp_dload = 32'hA5A50100;
      n_cmp++;
      if (nd != 1 || ni != 1) begin
         n_bad++; $display("FAIL prio_counts: got d=%0d i=%0d want 1 1", nd, ni);
      end
   endtask

   task automatic test_write();
      int exp_dh;
      ram_delay = 1;
      exp_dh = 1 + ram_delay + 1;
      daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1'b1; cyc = 0;
      for (int c = 1; c <= exp_dh + 1; c++) begin
         step();
         if (c == 1) begin
            n_cmp++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hDEADBEEF) begin
               n_bad++; $display("FAIL write_strobe: got wen=%b ren=%b addr=%h data=%h want 1 0 200 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
            end
         end else if (c == exp_dh) begin
            n_cmp++;
            if (dhit !== 1'b1 || dload !== exp_dload) begin
               n_bad++; $display("FAIL write_hit: got dhit=%b dload=%h want 1 %h", dhit, dload, exp_dload);
            end
         end else begin
            n_cmp++;
            if (dhit !== 1'b0) begin
               n_bad++; $display("FAIL write_pulse: cycle %0d got dhit=%b want 0", c, dhit);
            end
         end
      end
      n_cmp++;
      if (ram_rd(32'h200) !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL write_ram: got %h want deadbeef", ram_rd(32'h200));
      end
   endtask

   task automatic test_streak();
      byte seq[$];
      byte want[$];
      auto_drop_d = 1'b0;
      ram_delay = 0;
      daddr = 32'h300; dREN = 1'b1; iaddr = 32'h48; iREN = 1'b1; cyc = 0;
      repeat (24) begin
         step();
         if (dhit) seq.push_back("D");
         if (ihit) seq.push_back("I");
      end
      dREN = 1'b0;
      repeat (MAX_DSTREAK) want.push_back("D");
      want.push_back("I");
      want.push_back("D");
      for (int k = 0; k < want.size(); k++) begin
         n_cmp++;
         if (k >= seq.size() || seq[k] != want[k]) begin
            n_bad++; $display("FAIL streak_order: hit %0d got %s want %s", k, (k < seq.size()) ? string'(seq[k]) : "none", string'(want[k]));
         end
      end
      repeat (6) step();
      auto_drop_d = 1'b1;
      exp_dload = ram_rd(32'h300);
   endtask

   task automatic test_timeout(input bit data_side);
      bit early = 1'b0;
      ram_tie0 = 1'b1;
      if (data_side) begin daddr = 32'h500; dREN = 1'b1; end
      else           begin iaddr = 32'h50;  iREN = 1'b1; end
      cyc = 0;
      for (int c = 1; c <= TIMEOUT + 2; c++) begin
         step();
         if (c <= TIMEOUT && (merr || ihit || dhit)) early = 1'b1;
         if (c == TIMEOUT) begin
            n_cmp++;
            if ((data_side ? ramREN : ramREN) !== 1'b1) begin
               n_bad++; $display("FAIL timeout_busy: got ren=%b want 1", ramREN);
            end
         end
         if (c == TIMEOUT + 1) begin
            n_cmp++;
            if (merr !== 1'b1 || (data_side ? dhit : ihit) !== 1'b1 || (data_side ? ihit : dhit) !== 1'b0 ||
                (data_side ? dload : iload) !== 32'hBAD1BAD1 || ramREN !== 1'b0) begin
               n_bad++; $display("FAIL timeout_hit: side=%0d got merr=%b ihit=%b dhit=%b load=%h ren=%b", data_side, merr, ihit, dhit, data_side ? dload : iload, ramREN);
            end
         end
         if (c == TIMEOUT + 2) begin
            n_cmp++;
            if (merr !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0 || ramREN !== 1'b0) begin
               n_bad++; $display("FAIL timeout_idle: got merr=%b ihit=%b dhit=%b ren=%b want 0", merr, ihit, dhit, ramREN);
            end
         end
      end
      n_cmp++;
      if (early) begin
         n_bad++; $display("FAIL timeout_early: got early hit/merr want none before cycle %0d", TIMEOUT + 1);
      end
      if (data_side) exp_dload = 32'hBAD1BAD1;
      ram_tie0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int hits = 0;
      ram_delay = 6;
      daddr = 32'h400; dREN = 1'b1; cyc = 0;
      repeat (2) step();
      n_cmp++;
      if (ramREN !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_busy: got ren=%b want 1", ramREN);
      end
      nRST = 1'b0;
      #1;
      n_cmp++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_strobe: got ren=%b wen=%b want 0 0", ramREN, ramWEN);
      end
      dREN = 1'b0;
      repeat (3) begin step(); hits += int'(dhit); end
      @(negedge clk);
      nRST = 1'b1;
      repeat (6) begin step(); hits += int'(dhit); end
      n_cmp++;
      if (hits != 0) begin
         n_bad++; $display("FAIL rstmid_nohit: got %0d hits want 0", hits);
      end
      ram_mem[32'h404] = 32'h0BADF00D;
      ram_delay = 1;
      daddr = 32'h404; dREN = 1'b1; cyc = 0;
      repeat (3) step();
      n_cmp++;
      if (dhit !== 1'b1 || dload !== 32'h0BADF00D) begin
         n_bad++; $display("FAIL rstmid_resume: got dhit=%b dload=%h want 1 0badf00d", dhit, dload);
      end
      exp_dload = 32'h0BADF00D;
      repeat (2) step();
   endtask

   task automatic test_random();
      bit          i_pend = 0, d_pend = 0, d_wr = 0;
      logic [31:0] i_a = 0, d_a = 0, d_v = 0;
      int          i_t = 0, d_t = 0, dcount = 0;
      ref_mem    = ram_mem;
      rand_delay = 1'b1;
      junk_en    = 1'b1;
      cyc = 0;
      for (int t = 1; t <= 3000; t++) begin
         step();
         n_cmp++;
         if ((ihit && dhit) || (ramREN && ramWEN)) begin
            n_bad++; $display("FAIL rand_onehot: cycle %0d got ihit=%b dhit=%b ren=%b wen=%b", t, ihit, dhit, ramREN, ramWEN);
         end
         if (ihit) begin
            n_cmp++;
            if (!i_pend || iload !== ref_rd(i_a) || merr !== 1'b0 || t - i_t < 2 || dcount > MAX_DSTREAK + 1) begin
               n_bad++; $display("FAIL rand_ihit: cycle %0d pend=%b load=%h want %h merr=%b lat=%0d dstreak=%0d", t, i_pend, iload, ref_rd(i_a), merr, t - i_t, dcount);
            end
            i_pend = 1'b0;
         end
         if (dhit) begin
            if (!d_wr) exp_dload = ref_rd(d_a);
            n_cmp++;
            if (!d_pend || dload !== exp_dload || merr !== 1'b0 || t - d_t < 2) begin
               n_bad++; $display("FAIL rand_dhit: cycle %0d pend=%b wr=%b load=%h want %h merr=%b lat=%0d", t, d_pend, d_wr, dload, exp_dload, merr, t - d_t);
            end
            if (d_wr) ref_mem[d_a] = d_v;
            if (i_pend) dcount++;
            d_pend = 1'b0;
         end
         if ((i_pend && t - i_t > 100) || (d_pend && t - d_t > 100)) begin
            n_cmp++; n_bad++;
            $display("FAIL rand_watchdog: cycle %0d got no hit within 100 cycles", t);
            break;
         end
         if (!i_pend && !ihit && $urandom_range(0, 2) == 0) begin
            i_a = 32'h1000 + ($urandom_range(0, 15) << 2);
            iaddr = i_a; iREN = 1'b1; i_pend = 1'b1; i_t = t; dcount = 0;
         end
         if (!d_pend && !dhit && $urandom_range(0, 1) == 0) begin
            d_a  = 32'h1000 + ($urandom_range(0, 15) << 2);
            d_wr = 1'($urandom_range(0, 1));
            d_v  = $urandom;
            daddr = d_a; dstore = d_v; dWEN = d_wr; dREN = ~d_wr | 1'($urandom_range(0, 1));
            d_pend = 1'b1; d_t = t;
         end
      end
      rand_delay = 1'b0;
      junk_en    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ifetch();
      test_drop_mid();
      test_priority();
      test_write();
      test_streak();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got simulation still running want finished");
      $fatal(1, "bench time limit expired");
   end

endmodule
`default_nettype wire
